// File: rtl/krnl_partialknn_local_sp_pkg.sv
// Shared types and default sizing for the partial-kNN local single-port streamer.
package krnl_partialknn_local_sp_pkg;

  localparam int DEF_DATA_WIDTH   = 256;
  localparam int DEF_ADDR_WIDTH   = 11;
  localparam int DEF_DEPTH        = 2048;
  localparam int DEF_READ_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/krnl_partialknn_local_sp_rdbuf.sv
// Read-return tracking and small output FIFO for the scan stream.
// Reads are tracked by a valid shift register of READ_LATENCY stages; the
// returning word is registered into a READ_LATENCY+1 deep FIFO.
module krnl_partialknn_local_sp_rdbuf
  import krnl_partialknn_local_sp_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_issue,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_out_ready,
  output logic                  o_can_issue,
  output logic                  o_idle,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW        = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LP_LAST  = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0]   LP_LIMIT = (CW+1)'(BUF_DEPTH);

  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0]   r_buf [BUF_DEPTH];
  logic [PW-1:0]           r_wp;
  logic [PW-1:0]           r_rp;
  logic [CW-1:0]           r_cnt;

  logic        w_push;
  logic        w_pop;
  logic [CW:0] w_inflight;
  logic [CW:0] w_used;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LP_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_push  = r_vld[READ_LATENCY-1];
  assign o_valid = (r_cnt != '0);
  assign w_pop   = o_valid && i_out_ready;
  assign o_data  = r_buf[r_rp];
  assign o_idle  = (r_cnt == '0) && (r_vld == '0);

  // Count reads still travelling through the memory pipeline.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + (CW+1)'(r_vld[i]);
    end
  end

  // Occupancy is taken after this cycle's pop so that a steady
  // issue/pop stream never stalls; every in-flight word still has a slot.
  assign w_used      = {1'b0, r_cnt} + w_inflight - (CW+1)'(w_pop);
  assign o_can_issue = (w_used < LP_LIMIT);

  // Valid shift register, FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_issue;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_push) begin
        r_buf[r_wp] <= i_rd_data;
        r_wp        <= f_next(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_next(r_rp);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/krnl_partialknn_local_sp_streamer.sv
// Load-then-scan streamer over a single-port local buffer: a job writes
// len words from the input stream into the buffer, then reads them back
// in order onto the output stream, honouring output backpressure.
module krnl_partialknn_local_sp_streamer
  import krnl_partialknn_local_sp_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

  state_e              r_state;
  logic [ADDR_WIDTH:0] r_len;
  logic [ADDR_WIDTH:0] r_wr_cnt;
  logic [ADDR_WIDTH:0] r_rd_cnt;

  logic [ADDR_WIDTH:0] w_len_clamp;
  logic [ADDR_WIDTH:0] w_wr_next;
  logic [ADDR_WIDTH:0] w_rd_next;
  logic                w_wr;
  logic                w_rd;
  logic                w_can_issue;
  logic                w_buf_idle;

  assign w_len_clamp = (num_words > LP_DEPTH) ? LP_DEPTH : num_words;
  assign w_wr_next   = r_wr_cnt + LP_ONE;
  assign w_rd_next   = r_rd_cnt + LP_ONE;

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_FIN);
  assign in_ready = (r_state == ST_LOAD);
  assign w_wr     = in_ready && in_valid;
  assign w_rd     = (r_state == ST_SCAN) && w_can_issue;

  // Memory port mux: write beat, read issue, or quiet (address/data zero).
  always_comb begin
    mem_ce0      = w_wr || w_rd;
    mem_we0      = w_wr;
    mem_address0 = '0;
    mem_d0       = '0;
    if (w_wr) begin
      mem_address0 = r_wr_cnt[ADDR_WIDTH-1:0];
      mem_d0       = in_data;
    end else if (w_rd) begin
      mem_address0 = r_rd_cnt[ADDR_WIDTH-1:0];
    end
  end

  // Job sequencing and write/read counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len    <= w_len_clamp;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_state  <= (w_len_clamp == '0) ? ST_FIN : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_wr) begin
            if (w_wr_next == r_len) begin
              r_wr_cnt <= '0;
              r_state  <= ST_SCAN;
            end else begin
              r_wr_cnt <= w_wr_next;
            end
          end
        end
        ST_SCAN: begin
          if (w_rd) begin
            r_rd_cnt <= w_rd_next;
            if (w_rd_next == r_len) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_buf_idle) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  krnl_partialknn_local_sp_rdbuf #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdbuf (
    .clk         (clk),
    .i_rst_n     (reset),
    .i_issue     (w_rd),
    .i_rd_data   (mem_q0),
    .i_out_ready (out_ready),
    .o_can_issue (w_can_issue),
    .o_idle      (w_buf_idle),
    .o_data      (out_data),
    .o_valid     (out_valid)
  );

endmodule

// File: tb/tb_krnl_partialknn_local_sp_streamer.sv
// Bench for the local single-port streamer: two instances (read latency 1
// and 3) share stimulus; each has its own memory model and scoreboard queue.
`timescale 1ns/1ps
module tb_krnl_partialknn_local_sp_streamer;

  localparam int DW    = 256;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW:0]   num_words = '0;
  logic [DW-1:0] in_data   = '0;

  logic [1:0]    w_busy, w_done, w_in_ready, w_out_valid, w_ce, w_we;
  logic [DW-1:0] w_out_data [2];
  logic [DW-1:0] w_d        [2];
  logic [DW-1:0] w_q        [2];
  logic [AW-1:0] w_addr     [2];

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int n_wr [2];
  int n_rd [2];
  int n_out [2];
  int n_done [2];
  int n_busy [2];
  int n_gap [2];
  int rdy_mode = 0;
  int job_len  = 0;
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [DW-1:0] d);
    q0.push_back(d);
    q1.push_back(d);
  endfunction

  function automatic void pop_exp(input int idx, output logic ok, output logic [DW-1:0] d);
    ok = 1'b0;
    d  = '0;
    if (idx == 0) begin
      if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
    end
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int RL = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] qp  [RL];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    krnl_partialknn_local_sp_streamer #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .DEPTH        (DEPTH),
      .READ_LATENCY (RL)
    ) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .start        (start),
      .num_words    (num_words),
      .busy         (w_busy[g]),
      .done         (w_done[g]),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (w_in_ready[g]),
      .out_data     (w_out_data[g]),
      .out_valid    (w_out_valid[g]),
      .out_ready    (out_ready),
      .mem_address0 (w_addr[g]),
      .mem_ce0      (w_ce[g]),
      .mem_we0      (w_we[g]),
      .mem_d0       (w_d[g]),
      .mem_q0       (w_q[g])
    );

    // Single-port RAM with RL-cycle registered read data.
    always @(posedge clk) begin
      if (w_ce[g] && w_we[g]) mem[w_addr[g]] <= w_d[g];
      qp[0] <= (w_ce[g] && !w_we[g]) ? mem[w_addr[g]] : '0;
      for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
    end
    assign w_q[g] = qp[RL-1];

    // Per-instance monitor and scoreboard consumer.
    always @(negedge clk) begin : mon
      logic          ok;
      logic [DW-1:0] e;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (start && !w_busy[g]) begin
          n_wr[g] = 0; n_rd[g] = 0; n_out[g] = 0;
          n_done[g] = 0; n_busy[g] = 0; n_gap[g] = 0;
        end
        if (w_busy[g]) n_busy[g]++;
        if (w_done[g]) n_done[g]++;
        if (w_ce[g] && w_we[g]) begin
          chk($sformatf("wr_addr%0d", g), DW'(w_addr[g]), DW'(n_wr[g] % DEPTH));
          chk($sformatf("wr_data%0d", g), w_d[g], in_data);
          n_wr[g]++;
        end
        if (w_ce[g] && !w_we[g]) begin
          chk($sformatf("rd_addr%0d", g), DW'(w_addr[g]), DW'(n_rd[g] % DEPTH));
          n_rd[g]++;
        end
        if (prev_stall) begin
          chk($sformatf("hold_valid%0d", g), DW'(w_out_valid[g]), DW'(1));
          chk($sformatf("hold_data%0d", g), w_out_data[g], prev_data);
        end
        if (rdy_mode == 0 && n_out[g] > 0 && n_out[g] < job_len && !w_out_valid[g]) n_gap[g]++;
        if (w_out_valid[g] && out_ready) begin
          pop_exp(g, ok, e);
          chk($sformatf("out_expected%0d", g), DW'(ok), DW'(1));
          chk($sformatf("out_data%0d", g), w_out_data[g], e);
          n_out[g]++;
        end
        prev_stall = w_out_valid[g] && !out_ready;
        prev_data  = w_out_data[g];
      end
    end
  end

  // Output backpressure: always ready, or the repeating 1,0,0,1 pattern.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : pat[k % 4];
      k++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_busy%0d", tag, g),      DW'(w_busy[g]),      '0);
      chk($sformatf("%s_done%0d", tag, g),      DW'(w_done[g]),      '0);
      chk($sformatf("%s_in_ready%0d", tag, g),  DW'(w_in_ready[g]),  '0);
      chk($sformatf("%s_out_valid%0d", tag, g), DW'(w_out_valid[g]), '0);
      chk($sformatf("%s_ce%0d", tag, g),        DW'(w_ce[g]),        '0);
      chk($sformatf("%s_we%0d", tag, g),        DW'(w_we[g]),        '0);
      chk($sformatf("%s_out_data%0d", tag, g),  w_out_data[g],       '0);
      chk($sformatf("%s_addr%0d", tag, g),      DW'(w_addr[g]),      '0);
      chk($sformatf("%s_d%0d", tag, g),         w_d[g],              '0);
    end
  endtask

  task automatic load_words(input int n, input bit poke, input bit fixed);
    logic [DW-1:0] d;
    bit ok;
    for (int i = 0; i < n; i++) begin
      d = fixed ? DW'(32'hA0 + i) : rand_word();
      in_data  = d;
      in_valid = 1'b1;
      if (poke && i == 2) begin start = 1'b1; num_words = (AW+1)'(5); end
      ok = 1'b0;
      for (int b = 0; b < 50 && !ok; b++) begin
        @(negedge clk);
        ok = w_in_ready[0];
      end
      if (!ok) begin
        chk("load_timeout", '0, DW'(1));
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      push_exp(d);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int nw, input int exp_len, input int mode, input bit poke, input bit fixed);
    bit ok;
    rdy_mode  = mode;
    job_len   = exp_len;
    num_words = (AW+1)'(nw);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_words(exp_len, poke, fixed);
    if (poke) begin
      ok = 1'b0;
      for (int b = 0; b < 200 && !ok; b++) begin
        @(posedge clk); #2;
        ok = (n_out[0] >= 2);
      end
      if (!ok) chk("scan_poke_timeout", '0, DW'(1));
      start = 1'b1;
      num_words = (AW+1)'(5);
      @(posedge clk); #1;
      start = 1'b0;
    end
    ok = 1'b0;
    for (int b = 0; b < exp_len * 4 + 100 && !ok; b++) begin
      @(posedge clk); #2;
      ok = (n_done[0] > 0) && (n_done[1] > 0) && (w_busy == 2'b00);
    end
    if (!ok) chk($sformatf("done_timeout_len%0d", exp_len), '0, DW'(1));
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("n_wr%0d_len%0d", g, exp_len),   DW'(n_wr[g]),   DW'(exp_len));
      chk($sformatf("n_rd%0d_len%0d", g, exp_len),   DW'(n_rd[g]),   DW'(exp_len));
      chk($sformatf("n_out%0d_len%0d", g, exp_len),  DW'(n_out[g]),  DW'(exp_len));
      chk($sformatf("n_done%0d_len%0d", g, exp_len), DW'(n_done[g]), DW'(1));
      if (exp_len == 0) chk($sformatf("n_busy%0d_len0", g), DW'(n_busy[g]), DW'(1));
      if (mode == 0) chk($sformatf("n_gap%0d_len%0d", g, exp_len), DW'(n_gap[g]), '0);
    end
    chk("q0_empty", DW'(q0.size()), '0);
    chk("q1_empty", DW'(q1.size()), '0);
  endtask

  task automatic reset_test();
    bit ok;
    rdy_mode  = 0;
    job_len   = 16;
    num_words = (AW+1)'(16);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_words(16, 1'b0, 1'b0);
    ok = 1'b0;
    for (int b = 0; b < 200 && !ok; b++) begin
      @(posedge clk); #2;
      ok = (n_out[0] >= 5);
    end
    if (!ok) chk("rst_wait_timeout", '0, DW'(1));
    chk("rst_at_out5", DW'(n_out[0]), DW'(5));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob");
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) chk($sformatf("rst_no_done%0d", g), DW'(n_done[g]), '0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(4,    4,    0, 1'b0, 1'b1);
    run_job(8,    8,    1, 1'b1, 1'b0);
    run_job(2048, 2048, 0, 1'b0, 1'b0);
    run_job(0,    0,    0, 1'b0, 1'b0);
    run_job(3000, 2048, 1, 1'b0, 1'b0);
    reset_test();
    run_job(3,    3,    1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/krnl_partialknn_local_sp_streamer.md
KRNL_PARTIALKNN_LOCAL_SP_STREAMER -- requirements
Module: krnl_partialKnn_local_sp_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, width of one buffer word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, buffer address width.
REQ-003 SHALL have parameter DEPTH, default 2048, number of buffer words.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from mem_ce0 (read) to valid mem_q0.
REQ-005 SHALL have ports: clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  begin a load-then-scan job; sampled only in IDLE.
REQ-008 SHALL have port num_words  in  ADDR_WIDTH+1  job length in words; latched on accepted start.
REQ-009 SHALL have ports busy  out  1  (high outside IDLE) and done  out  1  (one-cycle pulse at job end).
REQ-010 SHALL have ports in_data  in  DATA_WIDTH, in_valid  in  1, in_ready  out  1  (load stream).
REQ-011 SHALL have ports out_data  out  DATA_WIDTH, out_valid  out  1, out_ready  in  1  (scan stream).
REQ-012 SHALL have memory-side ports mem_address0  out  ADDR_WIDTH, mem_ce0  out  1, mem_we0  out  1, mem_d0  out  DATA_WIDTH, mem_q0  in  DATA_WIDTH, driving the single-port local buffer.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SCAN, DRAIN, FIN.
REQ-014 IDLE: start=1 latches len=min(num_words, DEPTH); len=0 -> FIN, else -> LOAD; start outside IDLE ignored.
REQ-015 LOAD: in_ready=1; each beat with in_valid&in_ready drives mem_ce0=1, mem_we0=1, mem_address0=wr_cnt, mem_d0=in_data, same cycle (combinational pass-through).
REQ-016 LOAD: wr_cnt increments per accepted beat; beat number len -> SCAN next cycle, wr_cnt cleared; in_ready=0 in all other states.
REQ-017 SCAN: read issued (mem_ce0=1, mem_we0=0, mem_address0=rd_cnt) only when inflight+occupancy < READ_LATENCY+1; after len issues -> DRAIN.
REQ-018 Read data SHALL be captured into the output buffer exactly READ_LATENCY cycles after issue, via a valid shift register; no data loss under any out_ready pattern.
REQ-019 Output buffer depth READ_LATENCY+1, FIFO order; out_valid=not empty; pop on out_valid&out_ready; push and pop in the same cycle allowed.
REQ-020 With out_ready held high, SCAN SHALL sustain one word per cycle; first out_valid READ_LATENCY cycles after first issue (+0 cycle buffer pass-through not permitted; data registered).
REQ-021 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 DRAIN -> FIN when no read in flight and buffer empty; FIN asserts done=1 for one cycle, then IDLE.
REQ-023 mem_ce0=0, mem_we0=0 whenever no write/read issued; mem_address0/mem_d0 are don't-care then but SHALL be 0 in IDLE.
REQ-024 Counters are ADDR_WIDTH+1 bits; len=DEPTH SHALL complete without wrap; address uses low ADDR_WIDTH bits.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, counters 0, buffer empty, shift register cleared.
REQ-026 During reset: busy, done, in_ready, out_valid, mem_ce0, mem_we0 = 0; out_data, mem_address0, mem_d0 = 0.
REQ-027 Reset mid-job SHALL abandon the job; no done pulse; in-flight read data discarded.

Structure
REQ-028 Shared package krnl_partialKnn_local_sp_pkg SHALL hold the state enum and default width/depth constants.
REQ-029 Output buffer plus inflight tracking SHALL be sub-module krnl_partialKnn_local_sp_rdbuf.

Verification
REQ-030 len=4, words 0xA0..0xA3 with in_valid always 1 -> 4 writes addr 0..3; out stream 0xA0..0xA3; done one pulse.
REQ-031 len=2048, out_ready always 1 -> 2048 outputs, one per cycle in steady state, last addr 0x7FF, no wrap, done once.
REQ-032 len=8, out_ready toggling 1,0,0,1 -> all 8 words in order, out_data stable while stalled, READ_LATENCY=1 and 3 both pass.
REQ-033 num_words=0 -> busy one cycle, no mem_ce0, done pulse; num_words=3000 -> clamped to 2048.
REQ-034 reset=0 asserted in SCAN after 5 outputs -> all outputs 0 immediately, no done; following job len=3 runs cleanly.
REQ-035 start pulsed during LOAD and SCAN -> ignored; len and counters unchanged.
